// File: rtl/iter_mag_comparator_pkg.sv
// Shared definitions for the iterative magnitude comparator: FSM states,
// one-hot result codes and a width helper for the digit counter.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result vector ordering is {gt, eq, lt}
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  // Bits needed to index n items; never less than 1 so a counter always exists
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iter_mag_comparator_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-wide slice of each operand.
module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             dgt,
  output logic             dlt
);

  assign dgt = (x > y);
  assign dlt = (x < y);

endmodule

// File: rtl/iter_mag_comparator.sv
// Registered magnitude comparator scanning operands MSB-first, DIGIT bits per
// cycle, with an early exit on the first differing digit.
module iter_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = clog2(NDIG);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    IDX_TOP  = CW'(NDIG - 1);

  if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("iter_mag_comparator: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    idx_r;
  logic [2:0]       res_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic             dgt_s;
  logic             dlt_s;

  // Select the digit currently under comparison
  always_comb begin
    a_dig_s = a_r[int'(idx_r) * DIGIT +: DIGIT];
    b_dig_s = b_r[int'(idx_r) * DIGIT +: DIGIT];
  end

  digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .x   (a_dig_s),
    .y   (b_dig_s),
    .dgt (dgt_s),
    .dlt (dlt_s)
  );

  // Control FSM, operand capture, digit counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      idx_r       <= '0;
      res_r       <= 3'b000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order
            a_r        <= signed_mode ? (a ^ MSB_MASK) : a;
            b_r        <= signed_mode ? (b ^ MSB_MASK) : b;
            idx_r      <= IDX_TOP;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_CMP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CMP: begin
          if (dgt_s || dlt_s) begin
            res_r       <= dgt_s ? RES_GT : RES_LT;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (idx_r == '0) begin
            res_r       <= RES_EQ;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            idx_r   <= idx_r - CW'(1);
            state_r <= ST_CMP;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign gt        = res_r[2];
  assign eq        = res_r[1];
  assign lt        = res_r[0];

endmodule

// File: tb/tb_iter_mag_comparator.sv
// Self-checking bench: directed and random transactions on an 8/2 instance,
// plus exhaustive 4-bit pairs on DIGIT=1/2/4 instances run in lockstep.
module tb_iter_mag_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic       gt, eq, lt, busy;
  logic [7:0] a, b;

  logic       in_valid4, sm4, out_ready4;
  logic [3:0] a4, b4;
  logic [2:0] ir4, ov4, gt4, eq4, lt4, bz4;

  int n_tests = 0;
  int n_fail  = 0;

  iter_mag_comparator #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .gt(gt), .eq(eq), .lt(lt), .busy(busy)
  );

  iter_mag_comparator #(.WIDTH(4), .DIGIT(1)) u_dut4_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(ir4[0]),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(ov4[0]),
    .out_ready(out_ready4), .gt(gt4[0]), .eq(eq4[0]), .lt(lt4[0]), .busy(bz4[0])
  );

  iter_mag_comparator #(.WIDTH(4), .DIGIT(2)) u_dut4_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(ir4[1]),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(ov4[1]),
    .out_ready(out_ready4), .gt(gt4[1]), .eq(eq4[1]), .lt(lt4[1]), .busy(bz4[1])
  );

  iter_mag_comparator #(.WIDTH(4), .DIGIT(4)) u_dut4_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(ir4[2]),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(ov4[2]),
    .out_ready(out_ready4), .gt(gt4[2]), .eq(eq4[2]), .lt(lt4[2]), .busy(bz4[2])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer compare, result as {gt,eq,lt}
  function automatic logic [2:0] ref_res(input int av, input int bv, input bit sm, input int w);
    int sa, sb;
    sa = (sm && av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (sm && bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    if (sa > sb) return 3'b100;
    else if (sa == sb) return 3'b010;
    else return 3'b001;
  endfunction

  // Reference latency: one cycle per equal leading digit of the order-mapped values, plus one
  function automatic int ref_lat(input int av, input int bv, input bit sm, input int w, input int d);
    int ua, ub, ndig, lead, base;
    ndig = w / d;
    base = 1 << d;
    ua = sm ? (av ^ (1 << (w - 1))) : av;
    ub = sm ? (bv ^ (1 << (w - 1))) : bv;
    lead = 0;
    for (int i = ndig - 1; i >= 0; i--) begin
      if (((ua / (1 << (i * d))) % base) == ((ub / (1 << (i * d))) % base)) lead++;
      else break;
    end
    return (lead + 1 > ndig) ? ndig : lead + 1;
  endfunction

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit sm, input int stall);
    logic [2:0] er;
    int el, k;
    bit seen;
    er = ref_res(int'(av), int'(bv), sm, 8);
    el = ref_lat(int'(av), int'(bv), sm, 8, 2);
    @(negedge clk);
    check_val("rdy_before", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("busy_cmp", {31'd0, busy}, 32'd1);
    check_val("rdy_cmp", {31'd0, in_ready}, 32'd0);
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
        a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
      end
    end
    check_val("lat8", seen ? k : 32'hFFFF_FFFF, el);
    check_val("res8", {29'd0, gt, eq, lt}, {29'd0, er});
    for (int s = 0; s < stall; s++) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
      check_val("hold_ov", {31'd0, out_valid}, 32'd1);
      check_val("hold_rdy", {31'd0, in_ready}, 32'd0);
      check_val("hold_res", {29'd0, gt, eq, lt}, {29'd0, er});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("rel_ov", {31'd0, out_valid}, 32'd0);
    check_val("rel_rdy", {31'd0, in_ready}, 32'd1);
    check_val("rel_busy", {31'd0, busy}, 32'd0);
    check_val("rel_res", {29'd0, gt, eq, lt}, {29'd0, er});
  endtask

  task automatic run4(input int av, input int bv, input bit sm);
    int lat [3];
    bit seen [3];
    int dg;
    @(negedge clk);
    check_val("rdy4", {29'd0, ir4}, 32'd7);
    a4 = 4'(av); b4 = 4'(bv); sm4 = sm; in_valid4 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      seen[j] = 1'b0; lat[j] = -1;
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        if (!seen[j] && ov4[j]) begin
          seen[j] = 1'b1;
          lat[j] = c;
          check_val("res4", {29'd0, gt4[j], eq4[j], lt4[j]}, {29'd0, ref_res(av, bv, sm, 4)});
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      dg = (j == 0) ? 1 : (j == 1) ? 2 : 4;
      check_val("lat4", lat[j], ref_lat(av, bv, sm, 4, dg));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = 8'd0; b = 8'd0; signed_mode = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; sm4 = 1'b0; out_ready4 = 1'b1;
    #12;
    check_val("rst_rdy", {31'd0, in_ready}, 32'd1);
    check_val("rst_ov", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_res", {29'd0, gt, eq, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'hA5, 8'h5A, 1'b0, 0);
    run8(8'h3C, 8'h3C, 1'b0, 0);
    run8(8'hFF, 8'h01, 1'b1, 0);
    run8(8'hFF, 8'h01, 1'b0, 0);
    run8(8'h80, 8'h7F, 1'b1, 0);
    run8(8'($urandom), 8'($urandom), 1'($urandom), 5);

    // Reset while the comparator is mid-scan
    @(negedge clk);
    a = 8'h01; b = 8'h02; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mrst_ov", {31'd0, out_valid}, 32'd0);
    check_val("mrst_busy", {31'd0, busy}, 32'd0);
    check_val("mrst_rdy", {31'd0, in_ready}, 32'd1);
    check_val("mrst_res", {29'd0, gt, eq, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h01, 8'h02, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom);
      run8(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    for (int sm = 0; sm < 2; sm++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          run4(ia, ib, sm[0]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
